// File: rtl/rename_width_ctrl_pkg.sv
// Shared rename-stage definitions: reconfiguration FSM states, the widest front end,
// and the width-to-lane-mask decode shared with the rename/dispatch lane gating.
package rename_width_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        FLUSH  = 2'd2,
        SETTLE = 2'd3
    } rwc_state_t;

    localparam int FE_MAX_WIDTH = 4;

    // Lane 0 lives in the MSB, so a width of N enables the top N bits.
    function automatic logic [3:0] width_to_mask(input logic [2:0] width);
        logic [3:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(width)) begin
                mask[3-i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/rename_width_ctrl.sv
// Front-end width reconfiguration sequencer: stall, drain the ROB, recover the
// speculative free list, apply the new width/mask, settle, then release the stall.
module rename_width_ctrl
    import rename_width_ctrl_pkg::*;
#(
    parameter int MAX_WIDTH     = FE_MAX_WIDTH,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfgReq_i,
    input  logic [2:0] cfgWidth_i,
    input  logic       robEmpty_i,
    output logic       busy_o,
    output logic       cfgAck_o,
    output logic       cfgErr_o,
    output logic       stallFrontEnd_o,
    output logic       recoverFlag_o,
    output logic [2:0] frontEndWidth_o,
    output logic [3:0] frontEndMask_o
);

    localparam int CNT_MAX_VAL = (DRAIN_TIMEOUT > SETTLE_CYCLES) ? DRAIN_TIMEOUT : SETTLE_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX_VAL + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       DRAIN_LAST  = cnt_t'(DRAIN_TIMEOUT - 1);
    localparam cnt_t       SETTLE_LAST = cnt_t'(SETTLE_CYCLES - 1);
    localparam logic [2:0] RESET_WIDTH = 3'(MAX_WIDTH);

    rwc_state_t state_reg, state_next;
    cnt_t       cnt_reg, cnt_next, cnt_inc;
    logic [2:0] width_reg, width_next;
    logic [3:0] mask_reg, mask_next;
    logic [2:0] pend_width_reg, pend_width_next;
    logic       ack_reg, ack_next;
    logic       err_reg, err_next;

    // One counter serves both the drain timeout and the settle interval; it saturates.
    assign cnt_inc = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + cnt_t'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            width_reg      <= RESET_WIDTH;
            mask_reg       <= width_to_mask(RESET_WIDTH);
            pend_width_reg <= RESET_WIDTH;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            width_reg      <= width_next;
            mask_reg       <= mask_next;
            pend_width_reg <= pend_width_next;
            ack_reg        <= ack_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        width_next      = width_reg;
        mask_next       = mask_reg;
        pend_width_next = pend_width_reg;
        ack_next        = 1'b0;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cfgReq_i) begin
                    if (cfgWidth_i == 3'd0 || int'(cfgWidth_i) > MAX_WIDTH) begin
                        err_next = 1'b1;
                    end else if (cfgWidth_i == width_reg) begin
                        ack_next = 1'b1;
                    end else begin
                        pend_width_next = cfgWidth_i;
                        cnt_next        = '0;
                        state_next      = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // An empty ROB in the final timeout cycle still wins over the timeout.
                if (robEmpty_i) begin
                    state_next = FLUSH;
                end else if (cnt_reg == DRAIN_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            FLUSH: begin
                width_next = pend_width_reg;
                mask_next  = width_to_mask(pend_width_reg);
                cnt_next   = '0;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    ack_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy_o          = (state_reg != IDLE);
    assign stallFrontEnd_o = (state_reg != IDLE);
    assign recoverFlag_o   = (state_reg == FLUSH);
    assign cfgAck_o        = ack_reg;
    assign cfgErr_o        = err_reg;
    assign frontEndWidth_o = width_reg;
    assign frontEndMask_o  = mask_reg;

endmodule

// File: tb/tb_rename_width_ctrl.sv
// Self-checking bench for rename_width_ctrl: directed vector table, a reset-in-SETTLE
// sequence, and randomized requests checked against a transaction-level model.
module tb_rename_width_ctrl;

    localparam int DT = 16;
    localparam int SC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfgReq = 1'b0;
    logic [2:0] cfgWidth = 3'd0;
    logic       robEmpty = 1'b0;
    logic       busy, ack, err, stall, recover;
    logic [2:0] fe_width;
    logic [3:0] fe_mask;

    int checks = 0;
    int failures = 0;
    int model_width;

    always #5 clk = ~clk;

    rename_width_ctrl #(
        .MAX_WIDTH    (4),
        .DRAIN_TIMEOUT(DT),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cfgReq_i       (cfgReq),
        .cfgWidth_i     (cfgWidth),
        .robEmpty_i     (robEmpty),
        .busy_o         (busy),
        .cfgAck_o       (ack),
        .cfgErr_o       (err),
        .stallFrontEnd_o(stall),
        .recoverFlag_o  (recover),
        .frontEndWidth_o(fe_width),
        .frontEndMask_o (fe_mask)
    );

    typedef struct {
        int w;
        int d;
        bit spur;
        int e_ack;
        int e_err;
        int e_rec;
        int e_wchg;
        int e_width;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane mask as plain arithmetic: width N keeps the top N of four bits.
    function automatic int model_mask(input int w);
        return (15 << (4 - w)) & 15;
    endfunction

    // Cycle numbers count edges after the request edge; 0 means "never happens".
    function automatic void model_txn(input int w, input int d, input int cur,
                                      output int e_ack, output int e_err, output int e_rec,
                                      output int e_wchg, output int e_width);
        e_ack = 0; e_err = 0; e_rec = 0; e_wchg = 0; e_width = cur;
        if (w < 1 || w > 4) begin
            e_err = 1;
        end else if (w == cur) begin
            e_ack = 1;
        end else if (d >= DT) begin
            e_err = DT + 1;
        end else begin
            e_rec   = d + 2;
            e_wchg  = d + 3;
            e_ack   = d + 3 + SC;
            e_width = w;
        end
    endfunction

    task automatic run_txn(input string tag, input int w, input int d, input bit spur,
                           input int e_ack, input int e_err, input int e_rec,
                           input int e_wchg, input int e_width);
        int cyc, ack_at, err_at, rec_at, wchg_at, n_ack, n_err, n_busy, n_mis, start_w, e_end, done_at;
        start_w = int'(fe_width);
        e_end = (e_ack != 0) ? e_ack : e_err;
        cyc = 0; ack_at = 0; err_at = 0; rec_at = 0; wchg_at = 0;
        n_ack = 0; n_err = 0; n_busy = 0; n_mis = 0; done_at = 0;
        cfgReq = 1'b1;
        cfgWidth = 3'(w);
        robEmpty = (d == 0);
        while (cyc < 40 && (done_at == 0 || cyc < done_at + 2)) begin
            step();
            cyc++;
            cfgReq = spur && e_end >= 4 && (cyc == 2 || cyc == e_end - 1);
            if (cfgReq) cfgWidth = 3'($urandom_range(1, 4));
            robEmpty = (cyc - 1 >= d);
            if (ack) begin n_ack++; if (ack_at == 0) ack_at = cyc; end
            if (err) begin n_err++; if (err_at == 0) err_at = cyc; end
            if (recover && rec_at == 0) rec_at = cyc;
            if (int'(fe_width) != start_w && wchg_at == 0) wchg_at = cyc;
            if (busy) n_busy++;
            if (stall !== busy) n_mis++;
            if ((ack || err) && done_at == 0) done_at = cyc;
        end
        cfgReq = 1'b0;
        chk({tag, " ack_cycle"}, ack_at, e_ack);
        chk({tag, " err_cycle"}, err_at, e_err);
        chk({tag, " recover_cycle"}, rec_at, e_rec);
        chk({tag, " width_change_cycle"}, wchg_at, e_wchg);
        chk({tag, " ack_count"}, n_ack, (e_ack != 0) ? 1 : 0);
        chk({tag, " err_count"}, n_err, (e_err != 0) ? 1 : 0);
        chk({tag, " busy_cycles"}, n_busy, (e_end >= 2) ? e_end - 1 : 0);
        chk({tag, " stall_vs_busy"}, n_mis, 0);
        chk({tag, " final_width"}, int'(fe_width), e_width);
        chk({tag, " final_mask"}, int'(fe_mask), model_mask(e_width));
        $display("txn %s w=%0d d=%0d spur=%0d ack@%0d err@%0d rec@%0d width=%0d mask=%b",
                 tag, w, d, spur, ack_at, err_at, rec_at, fe_width, fe_mask);
    endtask

    initial begin
        int e_ack, e_err, e_rec, e_wchg, e_width, r, w, d, n_pulse;
        bit spur;

        vecs[0] = '{2, 0,  1'b0, 5,  0,  2,  3,  2};
        vecs[1] = '{2, 0,  1'b0, 1,  0,  0,  0,  2};
        vecs[2] = '{0, 0,  1'b0, 0,  1,  0,  0,  2};
        vecs[3] = '{5, 0,  1'b0, 0,  1,  0,  0,  2};
        vecs[4] = '{1, 10, 1'b0, 15, 0,  12, 13, 1};
        vecs[5] = '{3, 16, 1'b0, 0,  17, 0,  0,  1};
        vecs[6] = '{3, 15, 1'b0, 20, 0,  17, 18, 3};
        vecs[7] = '{4, 3,  1'b1, 8,  0,  5,  6,  4};
        vecs[8] = '{7, 0,  1'b0, 0,  1,  0,  0,  4};
        vecs[9] = '{4, 0,  1'b0, 1,  0,  0,  0,  4};

        // Reset values
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("reset width", int'(fe_width), 4);
        chk("reset mask", int'(fe_mask), 15);
        chk("reset busy", int'(busy), 0);
        chk("reset stall", int'(stall), 0);
        chk("reset ack", int'(ack), 0);
        chk("reset err", int'(err), 0);
        chk("reset recover", int'(recover), 0);
        $display("txn reset width=%0d mask=%b busy=%0d", fe_width, fe_mask, busy);

        // Reset asserted in SETTLE after width 3 was applied
        cfgReq = 1'b1; cfgWidth = 3'd3; robEmpty = 1'b1;
        step(); cfgReq = 1'b0;
        step();
        chk("midreset recover_in_flush", int'(recover), 1);
        step();
        chk("midreset width_applied", int'(fe_width), 3);
        chk("midreset busy_in_settle", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("midreset async_width", int'(fe_width), 4);
        chk("midreset async_mask", int'(fe_mask), 15);
        chk("midreset async_stall", int'(stall), 0);
        chk("midreset async_busy", int'(busy), 0);
        n_pulse = 0;
        repeat (2) begin step(); n_pulse += int'(ack) + int'(err); end
        reset = 1'b1;
        repeat (5) begin step(); n_pulse += int'(ack) + int'(err) + int'(busy); end
        chk("midreset no_ack_err_busy", n_pulse, 0);
        $display("txn midreset width=%0d mask=%b pulses=%0d", fe_width, fe_mask, n_pulse);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].d, vecs[i].spur,
                    vecs[i].e_ack, vecs[i].e_err, vecs[i].e_rec, vecs[i].e_wchg, vecs[i].e_width);
        end
        model_width = 4;

        // Randomized requests against the transaction model
        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(0, 6);
            r = $urandom_range(0, 9);
            d = (r < 7) ? $urandom_range(0, 4) : $urandom_range(13, 18);
            spur = 1'($urandom_range(0, 1));
            model_txn(w, d, model_width, e_ack, e_err, e_rec, e_wchg, e_width);
            run_txn($sformatf("rnd%0d", i), w, d, spur, e_ack, e_err, e_rec, e_wchg, e_width);
            model_width = e_width;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
